mem_responder: RTL

//   Bus-target memory that answers the load/store requests issued by the CPU core inside Chip.

---
 rtl/mem_responder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Bus-target data memory answering the core's load/store requests.
//   One request in flight at a time, valid/ready handshakes on the request
//   and response channels, a fixed programmable wait-state latency and
//   byte-enabled writes.
//
// Parameters
//   ADDR_W   word-address width of req_addr
//   DATA_W   data width (multiple of 8)
//   DEPTH    number of stored words (DEPTH <= 2**ADDR_W)
//   LATENCY  cycles from the accept edge to rsp_valid high (1..15)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  request can be accepted (high only while idle)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte enables for writes, bit i covers byte [8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  requester takes the response
//   rsp_rdata  read data, zero on write responses
//   rsp_err    error flag, meaningful while rsp_valid is high
//   busy       a transaction is waiting or being responded to
//
// Build option
//   MEM_BOUNDS_CHECK_EN  when defined, addresses >= DEPTH leave memory
//                        untouched, read as zero and raise rsp_err. When
//                        undefined, DEPTH must be a power of two, upper
//                        address bits alias and rsp_err is always zero.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The wait counter starts one below LATENCY because the WAIT->RESP edge
  // itself is the last of the LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]        cnt;
  logic              accept;
  logic              access;
  logic              rsp_done;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] access_rdata;
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  assign idx = lat_addr[IDX_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic err_q;

  assign in_range = ({1'b0, lat_addr} < DEPTH_L);
  assign rsp_err  = err_q;
`else
  assign in_range = 1'b1;
  assign rsp_err  = 1'b0;

  // Upper address bits are deliberately dropped so addresses alias onto
  // the power-of-two array; they are collected here only to show they are
  // intentionally left unused.
  if (IDX_W < ADDR_W) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = |lat_addr[ADDR_W-1:IDX_W];
  end
`endif

  assign rsp_rdata = rdata_q;

  // State register. Reset abandons whatever transaction was in flight and
  // brings the responder straight back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. req_ready is only ever high in IDLE,
  // so a request can never be taken on the same edge a response completes;
  // that gives the LATENCY+2 minimum spacing between requests.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Captures the request on the accept edge. Everything downstream works
  // from this copy, so the requester may change its inputs freely once the
  // request has been taken.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // Read data seen by the access edge: the whole stored word for a read
  // (byte enables do not matter), zero for writes and out-of-range reads.
  always_comb begin
    access_rdata = '0;
    if (!lat_we && in_range) begin
      access_rdata = mem[idx];
    end
  end

  // Wait-state counter and response registers. The counter stops at zero
  // rather than wrapping; the response data is loaded on the access edge,
  // held for the whole RESP phase and cleared once the requester takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      rdata_q <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt <= CNT_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        rdata_q <= access_rdata;
`ifdef MEM_BOUNDS_CHECK_EN
        err_q   <= ~in_range;
`endif
      end else if (rsp_done) begin
        rdata_q <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
        err_q   <= 1'b0;
`endif
      end
    end
  end

  // Storage array, never cleared. A write only lands on the WAIT->RESP edge
  // and is suppressed if reset is asserted on that very edge, so a reset
  // racing the access leaves the old contents intact.
  always_ff @(posedge clk) begin
    if (!rst && access && lat_we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (lat_be[i]) begin
          mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
